// File: rtl/reg_file.sv
// Architectural register file with rename tags: records the producing ROB entry at issue,
// retires values at commit, and answers two combinational operand queries with commit bypass.
module reg_file #(
  parameter int REG_NUM   = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [4:0]           reg_rd,
  input  logic [31:0]          reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [4:0]           rs1,
  output logic [31:0]          rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [4:0]           rs2,
  output logic [31:0]          rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [31:0]          val_q  [REG_NUM];
  logic                 busy_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q  [REG_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else begin
        if (reg_write && reg_rd != 5'd0) begin
          val_q[reg_rd] <= reg_val;
          // Only the current owner may release the register; a stale commit leaves it renamed.
          if (busy_q[reg_rd] && tag_q[reg_rd] == commit_rob_pos)
            busy_q[reg_rd] <= 1'b0;
        end
        // Placed after the commit so a same-cycle issue to the same rd keeps it busy.
        if (issue && issue_rd != 5'd0) begin
          busy_q[issue_rd] <= 1'b1;
          tag_q[issue_rd]  <= issue_rob_pos;
        end
      end
    end
  end

  always_comb begin
    rs1_val     = '0;
    rs1_busy    = 1'b0;
    rs1_rob_pos = '0;
    if (rs1 != 5'd0) begin
      if (reg_write && reg_rd == rs1 && busy_q[rs1] && tag_q[rs1] == commit_rob_pos) begin
        rs1_val     = reg_val;
        rs1_rob_pos = tag_q[rs1];
      end else begin
        rs1_val     = val_q[rs1];
        rs1_busy    = busy_q[rs1];
        rs1_rob_pos = tag_q[rs1];
      end
    end
  end

  always_comb begin
    rs2_val     = '0;
    rs2_busy    = 1'b0;
    rs2_rob_pos = '0;
    if (rs2 != 5'd0) begin
      if (reg_write && reg_rd == rs2 && busy_q[rs2] && tag_q[rs2] == commit_rob_pos) begin
        rs2_val     = reg_val;
        rs2_rob_pos = tag_q[rs2];
      end else begin
        rs2_val     = val_q[rs2];
        rs2_busy    = busy_q[rs2];
        rs2_rob_pos = tag_q[rs2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes predicted query results, a monitor pops and compares.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue, reg_write;
  logic [4:0]  issue_rd, reg_rd, rs1, rs2;
  logic [3:0]  issue_rob_pos, commit_rob_pos;
  logic [31:0] reg_val;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;

  int compared = 0;
  int mismatched = 0;

  reg_file #(.REG_NUM(32), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
    .rs1(rs1), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos),
    .rs2(rs2), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos)
  );

  always #5 clk = ~clk;

  // Reference model: committed value per register and the ROB entry that owns it (-1 = none).
  logic [31:0] mval  [32];
  int          owner [32];

  typedef struct {
    logic [4:0]  rs;
    logic        busy;
    logic [31:0] val;
    logic [3:0]  pos;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  function automatic exp_t predict(input logic [4:0] rs);
    exp_t e;
    e.rs = rs; e.busy = 1'b0; e.val = '0; e.pos = '0;
    if (rs == 5'd0) begin
      e.busy = 1'b0;
    end else if (reg_write && reg_rd == rs && owner[rs] == int'(commit_rob_pos)) begin
      e.val = reg_val;
    end else if (owner[rs] >= 0) begin
      e.busy = 1'b1;
      e.pos  = 4'(owner[rs]);
    end else begin
      e.val = mval[rs];
    end
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mval[i] = '0; owner[i] = -1; end
    end else if (rdy) begin
      if (rollback) begin
        for (int i = 0; i < 32; i++) owner[i] = -1;
      end else begin
        if (reg_write && reg_rd != 5'd0) begin
          mval[reg_rd] = reg_val;
          if (owner[reg_rd] == int'(commit_rob_pos)) owner[reg_rd] = -1;
        end
        if (issue && issue_rd != 5'd0) owner[issue_rd] = int'(issue_rob_pos);
      end
    end
  endtask

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic step(input logic i_rst, input logic i_rdy, input logic i_rb,
                      input logic i_iss, input logic [4:0] i_ird, input logic [3:0] i_ipos,
                      input logic i_wr, input logic [4:0] i_rd, input logic [31:0] i_val,
                      input logic [3:0] i_cpos, input logic [4:0] i_rs1, input logic [4:0] i_rs2);
    @(posedge clk);
    #1;
    rst = i_rst; rdy = i_rdy; rollback = i_rb;
    issue = i_iss; issue_rd = i_ird; issue_rob_pos = i_ipos;
    reg_write = i_wr; reg_rd = i_rd; reg_val = i_val; commit_rob_pos = i_cpos;
    rs1 = i_rs1; rs2 = i_rs2;
    if (!i_rst) begin
      q1.push_back(predict(i_rs1));
      q2.push_back(predict(i_rs2));
    end
    model_update();
  endtask

  task automatic idle_query(input logic [4:0] a, input logic [4:0] b);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  // Monitor: DUT query outputs are valid for every enqueued cycle; sample at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check($sformatf("rs1_busy x%0d", e.rs), {31'd0, rs1_busy}, {31'd0, e.busy});
        if (e.busy) check($sformatf("rs1_rob_pos x%0d", e.rs), {28'd0, rs1_rob_pos}, {28'd0, e.pos});
        else        check($sformatf("rs1_val x%0d", e.rs), rs1_val, e.val);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check($sformatf("rs2_busy x%0d", e.rs), {31'd0, rs2_busy}, {31'd0, e.busy});
        if (e.busy) check($sformatf("rs2_rob_pos x%0d", e.rs), {28'd0, rs2_rob_pos}, {28'd0, e.pos});
        else        check($sformatf("rs2_val x%0d", e.rs), rs2_val, e.val);
      end
    end
  end

  initial begin
    logic [4:0] r;
    int budget;
    rst = 1; rdy = 1; rollback = 0; issue = 0; issue_rd = 0; issue_rob_pos = 0;
    reg_write = 0; reg_rd = 0; reg_val = 0; commit_rob_pos = 0; rs1 = 0; rs2 = 0;
    for (int i = 0; i < 32; i++) begin mval[i] = '0; owner[i] = -1; end

    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 5, 3, 1, 5, 32'hFFFF, 0, 0, 0);
    // Reset state and x0 immunity
    idle_query(5, 0);
    step(0, 1, 0, 1, 0, 9, 1, 0, 32'hDEAD, 0, 0, 0);
    idle_query(0, 31);
    // Issue x3@2, then commit with same-cycle bypass, then settled state
    step(0, 1, 0, 1, 3, 2, 0, 0, 0, 0, 3, 0);
    idle_query(3, 3);
    step(0, 1, 0, 0, 0, 0, 1, 3, 32'h1234, 2, 3, 0);
    idle_query(3, 0);
    // Stale commit: x4 renamed twice
    step(0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 4, 5, 0, 0, 0, 0, 4, 0);
    step(0, 1, 0, 0, 0, 0, 1, 4, 32'd7, 1, 4, 4);
    idle_query(4, 0);
    step(0, 1, 0, 0, 0, 0, 1, 4, 32'd9, 5, 4, 0);
    idle_query(0, 4);
    // Same-cycle commit and issue to x6
    step(0, 1, 0, 1, 6, 3, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 6, 8, 1, 6, 32'h55, 3, 6, 0);
    idle_query(6, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6, 32'h66, 8, 0, 0);
    idle_query(6, 6);
    // Rollback with an issue in the flush cycle
    step(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 7, 4, 0, 0, 0, 0, 1, 2);
    step(0, 1, 1, 1, 9, 6, 0, 0, 0, 0, 7, 0);
    idle_query(1, 2);
    idle_query(7, 9);
    idle_query(3, 4);
    // Stall: rdy low for 3 cycles with issue and commit asserted
    step(0, 1, 0, 1, 10, 2, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 11, 3, 1, 10, 32'hAAAA, 2, 10, 11);
    step(0, 1, 0, 1, 11, 3, 1, 10, 32'hAAAA, 2, 10, 11);
    idle_query(10, 11);

    // Randomized traffic; commit positions favour the current owner so releases occur
    for (int n = 0; n < 600; n++) begin
      logic [3:0] cp;
      r = 5'($urandom_range(0, 7));
      cp = 4'($urandom);
      if (owner[r] >= 0 && $urandom_range(0, 2) != 0) cp = 4'(owner[r]);
      step(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 29) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), 4'($urandom),
           1'($urandom), r, $urandom, cp,
           ($urandom_range(0, 1) != 0) ? r : 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    budget = 0;
    while ((q1.size() > 0 || q2.size() > 0) && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    compared++;
    if (q1.size() > 0 || q2.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
